ldpc_layer_sched: RTL and testbench
===================================

LDPC_LAYER_SCHED -- requirements
Module: ldpc_layer_sched

Interface
REQ-001 Parameter NUM_LAYERS, default 4, number of check-node layers per iteration.
REQ-002 Parameter NUM_COLS, default 24, number of circulant columns per layer.
REQ-003 Parameter MAX_ITER, default 8, maximum number of decoding iterations.
REQ-004 Parameter LW = clog2(NUM_LAYERS), CW = clog2(NUM_COLS), IW = clog2(MAX_ITER); each is a minimum of 1.
REQ-005 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1: reset; asynchronous and active-low.
REQ-007 Port start, input, 1: request to begin decoding one codeword.
REQ-008 Port abort, input, 1: synchronous cancel of the decode in progress.
REQ-009 Port cnu_done, input, 1: check-node unit has finished the current layer.
REQ-010 Port syn_ok, input, 1: syndrome is all-zero; sampled only in CHK.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port mem_rd_en, output, 1: read strobe for the LLR and R memories for column col_idx.
REQ-013 Port en_q_compute, output, 1: enable for the variable-node (q = q - r + LLR) register.
REQ-014 Port cnu_start, output, 1: single-cycle start pulse to the check-node unit.
REQ-015 Port wr_en, output, 1: write-back strobe for column col_idx.
REQ-016 Port col_idx, output, CW: current column address.
REQ-017 Port layer_idx, output, LW: current layer.
REQ-018 Port iter_cnt, output, IW: current iteration, counted from 0.
REQ-019 Port done, output, 1: single-cycle completion pulse.
REQ-020 Port success, output, 1: 1 means the codeword converged; the value is held until the next accepted start.

Function
REQ-021 The block has states IDLE, RD, DRAIN, CNU_ST, CNU_WT, WR, CHK and DONE, and all outputs are registered.
REQ-022 In IDLE, start=1 moves to RD and clears col_idx, layer_idx, iter_cnt and success.
- start in any other state is ignored.
REQ-023 In RD, mem_rd_en=1 and col_idx increments each cycle.
- When col_idx=NUM_COLS-1 the next state is DRAIN.
- RD therefore lasts exactly NUM_COLS cycles.
REQ-024 en_q_compute equals mem_rd_en delayed by one cycle (one-cycle memory read latency).
- It is high for NUM_COLS consecutive cycles, ending in DRAIN.
REQ-025 DRAIN lasts 1 cycle, then the next state is CNU_ST.
REQ-026 CNU_ST asserts cnu_start for exactly 1 cycle, then the next state is CNU_WT.
- cnu_done sampled during CNU_ST is ignored.
REQ-027 CNU_WT waits with no timeout; cnu_done=1 moves to WR and clears col_idx.
REQ-028 In WR, wr_en=1 and col_idx increments each cycle for NUM_COLS cycles.
- After the last column, if layer_idx=NUM_LAYERS-1 the next state is CHK.
- Otherwise layer_idx increments, col_idx clears, and the next state is RD.
REQ-029 CHK lasts 1 cycle.
- syn_ok=1: success=1, next state DONE.
- Otherwise, if iter_cnt=MAX_ITER-1: success=0, next state DONE.
- Otherwise: iter_cnt increments, layer_idx and col_idx clear, next state RD.
REQ-030 DONE asserts done=1 for 1 cycle, then the next state is IDLE.
REQ-031 One layer takes 2*NUM_COLS+2+k cycles, where k is the number of CNU_WT cycles (k≥1).
REQ-032 mem_rd_en, wr_en and cnu_start are mutually exclusive in every cycle.
REQ-033 Counters never exceed their terminal values: col_idx ≤ NUM_COLS-1, layer_idx ≤ NUM_LAYERS-1, iter_cnt ≤ MAX_ITER-1.
REQ-034 abort=1 in any non-IDLE state forces IDLE on the next edge.
- Strobes deassert, counters clear, success=0, and no done pulse is issued.
- abort has priority over every other transition, including cnu_done and syn_ok in the same cycle.
REQ-035 start and abort high together in IDLE leave the block in IDLE.

Reset
REQ-036 rst_n=0 immediately forces state IDLE and all outputs to 0, independent of clk.
REQ-037 Reset asserted mid-decode discards the decode; the first start after reset release begins from iteration 0, layer 0.

Verification
REQ-038 Defaults, start pulse, cnu_done 1 cycle after each cnu_start, syn_ok=1 at first CHK -> mem_rd_en 24 cycles per layer, 4 cnu_start pulses, done after 4*51+1 cycles in CHK/DONE path, success=1, iter_cnt=0.
REQ-039 syn_ok held 0 -> 8 iterations, iter_cnt reaches 7, done pulse with success=0, exactly 32 cnu_start pulses.
REQ-040 cnu_done delayed 10 cycles -> CNU_WT holds 10 cycles, no wr_en during wait, col_idx stable.
REQ-041 abort during layer 2 WR of iteration 3 -> IDLE next cycle, busy=0, no done, all counters 0; a new start decodes normally.
REQ-042 rst_n pulsed low during RD -> outputs 0 asynchronously; start pressed while busy -> no restart, counters unaffected.
REQ-043 The bench checks en_q_compute = mem_rd_en delayed by 1, and strobe mutual exclusion, in every cycle of all scenarios.

Source files
------------

// File: rtl/ldpc_layer_sched.sv
// Layered LDPC decode sequencer: per layer read columns, drain, kick the CNU, wait, write back; iterate until syndrome clears or MAX_ITER runs out.
// Latency: 2*NUM_COLS+2+k cycles per layer (k = CNU wait cycles), plus one CHK cycle per iteration and one DONE cycle.
// Backpressure: CNU_WT stalls indefinitely on cnu_done; abort cancels from any busy state; start is only accepted while idle.
module ldpc_layer_sched #(
   parameter int NUM_LAYERS = 4,
   parameter int NUM_COLS   = 24,
   parameter int MAX_ITER   = 8,
   parameter int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
   parameter int CW         = (NUM_COLS   > 1) ? $clog2(NUM_COLS)   : 1,
   parameter int IW         = (MAX_ITER   > 1) ? $clog2(MAX_ITER)   : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          cnu_done,
   input  logic          syn_ok,
   output logic          busy,
   output logic          mem_rd_en,
   output logic          en_q_compute,
   output logic          cnu_start,
   output logic          wr_en,
   output logic [CW-1:0] col_idx,
   output logic [LW-1:0] layer_idx,
   output logic [IW-1:0] iter_cnt,
   output logic          done,
   output logic          success
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD     = 3'd1,
      S_DRAIN  = 3'd2,
      S_CNU_ST = 3'd3,
      S_CNU_WT = 3'd4,
      S_WR     = 3'd5,
      S_CHK    = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   localparam logic [CW-1:0] COL_LAST   = CW'(NUM_COLS - 1);
   localparam logic [LW-1:0] LAYER_LAST = LW'(NUM_LAYERS - 1);
   localparam logic [IW-1:0] ITER_LAST  = IW'(MAX_ITER - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] col_idx_q, col_idx_d;
   logic [LW-1:0] layer_idx_q, layer_idx_d;
   logic [IW-1:0] iter_cnt_q, iter_cnt_d;
   logic          success_q, success_d;
   logic          busy_q, busy_d;
   logic          mem_rd_en_q, mem_rd_en_d;
   logic          en_q_compute_q, en_q_compute_d;
   logic          cnu_start_q, cnu_start_d;
   logic          wr_en_q, wr_en_d;
   logic          done_q, done_d;

   // Next-state and counter update; abort from a busy state overrides every other transition.
   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      layer_idx_d = layer_idx_q;
      iter_cnt_d  = iter_cnt_q;
      success_d   = success_q;

      if ((state_q != S_IDLE) && abort) begin
         state_d     = S_IDLE;
         col_idx_d   = '0;
         layer_idx_d = '0;
         iter_cnt_d  = '0;
         success_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // start together with abort is treated as no request
               if (start && !abort) begin
                  state_d     = S_RD;
                  col_idx_d   = '0;
                  layer_idx_d = '0;
                  iter_cnt_d  = '0;
                  success_d   = 1'b0;
               end
            end
            S_RD: begin
               // column index parks on the last column through DRAIN and the CNU wait
               if (col_idx_q == COL_LAST) begin
                  state_d = S_DRAIN;
               end else begin
                  col_idx_d = col_idx_q + CW'(1);
               end
            end
            S_DRAIN: begin
               state_d = S_CNU_ST;
            end
            S_CNU_ST: begin
               // cnu_done here belongs to no request yet, so it is not looked at
               state_d = S_CNU_WT;
            end
            S_CNU_WT: begin
               if (cnu_done) begin
                  state_d   = S_WR;
                  col_idx_d = '0;
               end
            end
            S_WR: begin
               if (col_idx_q == COL_LAST) begin
                  if (layer_idx_q == LAYER_LAST) begin
                     state_d = S_CHK;
                  end else begin
                     state_d     = S_RD;
                     layer_idx_d = layer_idx_q + LW'(1);
                     col_idx_d   = '0;
                  end
               end else begin
                  col_idx_d = col_idx_q + CW'(1);
               end
            end
            S_CHK: begin
               if (syn_ok) begin
                  success_d = 1'b1;
                  state_d   = S_DONE;
               end else if (iter_cnt_q == ITER_LAST) begin
                  success_d = 1'b0;
                  state_d   = S_DONE;
               end else begin
                  state_d     = S_RD;
                  iter_cnt_d  = iter_cnt_q + IW'(1);
                  layer_idx_d = '0;
                  col_idx_d   = '0;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Output strobes are decoded from the next state so they are registered yet line up with the state they describe.
   always_comb begin
      busy_d         = (state_d != S_IDLE);
      mem_rd_en_d    = (state_d == S_RD);
      cnu_start_d    = (state_d == S_CNU_ST);
      wr_en_d        = (state_d == S_WR);
      done_d         = (state_d == S_DONE);
      // one-cycle memory read latency: the q update sees data one cycle after the read strobe
      en_q_compute_d = mem_rd_en_q;
   end

   // State, counters and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         col_idx_q      <= '0;
         layer_idx_q    <= '0;
         iter_cnt_q     <= '0;
         success_q      <= 1'b0;
         busy_q         <= 1'b0;
         mem_rd_en_q    <= 1'b0;
         en_q_compute_q <= 1'b0;
         cnu_start_q    <= 1'b0;
         wr_en_q        <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         col_idx_q      <= col_idx_d;
         layer_idx_q    <= layer_idx_d;
         iter_cnt_q     <= iter_cnt_d;
         success_q      <= success_d;
         busy_q         <= busy_d;
         mem_rd_en_q    <= mem_rd_en_d;
         en_q_compute_q <= en_q_compute_d;
         cnu_start_q    <= cnu_start_d;
         wr_en_q        <= wr_en_d;
         done_q         <= done_d;
      end
   end

   assign busy         = busy_q;
   assign mem_rd_en    = mem_rd_en_q;
   assign en_q_compute = en_q_compute_q;
   assign cnu_start    = cnu_start_q;
   assign wr_en        = wr_en_q;
   assign col_idx      = col_idx_q;
   assign layer_idx    = layer_idx_q;
   assign iter_cnt     = iter_cnt_q;
   assign done         = done_q;
   assign success      = success_q;

`ifndef SYNTHESIS
   // The three memory/CNU strobes never overlap and counters stay within their terminal values.
   a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({mem_rd_en_q, wr_en_q, cnu_start_q}));
   a_col_bound: assert property (@(posedge clk) disable iff (!rst_n)
      col_idx_q <= COL_LAST);
   a_layer_bound: assert property (@(posedge clk) disable iff (!rst_n)
      layer_idx_q <= LAYER_LAST);
   a_iter_bound: assert property (@(posedge clk) disable iff (!rst_n)
      iter_cnt_q <= ITER_LAST);
`endif

endmodule

// File: tb/tb_ldpc_layer_sched.sv
// Directed bench for ldpc_layer_sched at default parameters (4 layers, 24 columns, 8 iterations).
// A background monitor checks the en_q delay, strobe exclusion and counter bounds every cycle.
// A background CNU model answers each cnu_start after a programmable number of cycles.
module tb_ldpc_layer_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       cnu_done;
   logic       syn_ok;
   logic       busy;
   logic       mem_rd_en;
   logic       en_q_compute;
   logic       cnu_start;
   logic       wr_en;
   logic [4:0] col_idx;
   logic [1:0] layer_idx;
   logic [2:0] iter_cnt;
   logic       done;
   logic       success;

   int   n_pass  = 0;
   int   n_total = 0;
   int   mon_err = 0;
   int   mon_cyc = 0;
   int   cnt_rd, cnt_wr, cnt_cnu, cnt_done;
   logic prev_rd = 1'b0;
   int   cnu_delay = 1;
   logic cnu_early = 1'b0;

   ldpc_layer_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .cnu_done     (cnu_done),
      .syn_ok       (syn_ok),
      .busy         (busy),
      .mem_rd_en    (mem_rd_en),
      .en_q_compute (en_q_compute),
      .cnu_start    (cnu_start),
      .wr_en        (wr_en),
      .col_idx      (col_idx),
      .layer_idx    (layer_idx),
      .iter_cnt     (iter_cnt),
      .done         (done),
      .success      (success)
   );

   always #5 clk = ~clk;

   // Per-cycle invariants and strobe counters, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_rd = 1'b0;
      end else begin
         mon_cyc++;
         if (en_q_compute !== prev_rd) begin
            mon_err++;
            if (mon_err <= 10) $display("FAIL en_q_delay t=%0t: en_q_compute=%b want %b", $time, en_q_compute, prev_rd);
         end
         if ((mem_rd_en & wr_en) | (mem_rd_en & cnu_start) | (wr_en & cnu_start)) begin
            mon_err++;
            if (mon_err <= 10) $display("FAIL strobe_excl t=%0t: rd/wr/cnu=%b%b%b want at most one", $time, mem_rd_en, wr_en, cnu_start);
         end
         if ((col_idx > 5'd23) || (layer_idx > 2'd3) || (iter_cnt > 3'd7)) begin
            mon_err++;
            if (mon_err <= 10) $display("FAIL bounds t=%0t: col=%0d layer=%0d iter=%0d", $time, col_idx, layer_idx, iter_cnt);
         end
         prev_rd = mem_rd_en;
         if (mem_rd_en) cnt_rd++;
         if (wr_en)     cnt_wr++;
         if (cnu_start) cnt_cnu++;
         if (done)      cnt_done++;
      end
   end

   // CNU model: raises cnu_done for one cycle, cnu_delay cycles after the cnu_start cycle.
   initial begin
      cnu_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && cnu_start) begin
            if (cnu_early) begin
               cnu_done = 1'b1;
               @(posedge clk);
               #1 cnu_done = 1'b0;
               repeat (cnu_delay - 1) @(posedge clk);
            end else begin
               repeat (cnu_delay) @(posedge clk);
            end
            #1 cnu_done = 1'b1;
            @(posedge clk);
            #1 cnu_done = 1'b0;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      cnt_rd = 0; cnt_wr = 0; cnt_cnu = 0; cnt_done = 0;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; syn_ok = 1'b0;
      repeat (3) @(negedge clk);
      n_total++; if (busy !== 1'b0)         $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (mem_rd_en !== 1'b0)    $display("FAIL reset_rd: got %b want 0", mem_rd_en); else n_pass++;
      n_total++; if (en_q_compute !== 1'b0) $display("FAIL reset_enq: got %b want 0", en_q_compute); else n_pass++;
      n_total++; if (cnu_start !== 1'b0)    $display("FAIL reset_cnu: got %b want 0", cnu_start); else n_pass++;
      n_total++; if (wr_en !== 1'b0)        $display("FAIL reset_wr: got %b want 0", wr_en); else n_pass++;
      n_total++; if (done !== 1'b0)         $display("FAIL reset_done: got %b want 0", done); else n_pass++;
      n_total++; if (success !== 1'b0)      $display("FAIL reset_success: got %b want 0", success); else n_pass++;
      n_total++; if ({col_idx, layer_idx, iter_cnt} !== 10'd0)
         $display("FAIL reset_counters: col=%0d layer=%0d iter=%0d want 0", col_idx, layer_idx, iter_cnt); else n_pass++;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL idle_no_start: busy=%b want 0", busy); else n_pass++;
   endtask

   task automatic test_nominal();
      int got;
      got = -1;
      syn_ok = 1'b1; cnu_delay = 1; cnu_early = 1'b0;
      pulse_start();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (n == 0) begin
            n_total++; if ({busy, mem_rd_en} !== 2'b11) $display("FAIL nom_first_rd: busy/rd=%b want 11", {busy, mem_rd_en}); else n_pass++;
            n_total++; if ({col_idx, layer_idx, iter_cnt} !== 10'd0)
               $display("FAIL nom_first_idx: col=%0d layer=%0d iter=%0d want 0", col_idx, layer_idx, iter_cnt); else n_pass++;
         end
         if (n == 23) begin
            n_total++; if ({mem_rd_en, col_idx} !== {1'b1, 5'd23}) $display("FAIL nom_last_rd: rd=%b col=%0d want 1/23", mem_rd_en, col_idx); else n_pass++;
         end
         if (n == 24) begin
            n_total++; if ({mem_rd_en, en_q_compute} !== 2'b01) $display("FAIL nom_drain: rd/enq=%b want 01", {mem_rd_en, en_q_compute}); else n_pass++;
         end
         if (n == 25) begin
            n_total++; if (cnu_start !== 1'b1) $display("FAIL nom_cnu_start: got %b want 1", cnu_start); else n_pass++;
         end
         if (n == 27) begin
            n_total++; if ({wr_en, col_idx} !== {1'b1, 5'd0}) $display("FAIL nom_wr_first: wr=%b col=%0d want 1/0", wr_en, col_idx); else n_pass++;
         end
         if (n == 51) begin
            n_total++; if ({mem_rd_en, layer_idx, col_idx} !== {1'b1, 2'd1, 5'd0})
               $display("FAIL nom_layer1: rd=%b layer=%0d col=%0d want 1/1/0", mem_rd_en, layer_idx, col_idx); else n_pass++;
         end
         if (done) begin
            got = n;
            n_total++; if ({busy, success, iter_cnt, layer_idx} !== {1'b1, 1'b1, 3'd0, 2'd3})
               $display("FAIL nom_done_state: busy=%b success=%b iter=%0d layer=%0d want 1/1/0/3", busy, success, iter_cnt, layer_idx); else n_pass++;
            break;
         end
      end
      n_total++; if (got != 205) $display("FAIL nom_latency: done at %0d want 205", got); else n_pass++;
      @(negedge clk);
      n_total++; if ({busy, done, success} !== 3'b001) $display("FAIL nom_after_done: busy/done/success=%b want 001", {busy, done, success}); else n_pass++;
      @(posedge clk);
      #1;
      n_total++; if (cnt_rd != 96)  $display("FAIL nom_rd_cycles: got %0d want 96", cnt_rd); else n_pass++;
      n_total++; if (cnt_wr != 96)  $display("FAIL nom_wr_cycles: got %0d want 96", cnt_wr); else n_pass++;
      n_total++; if (cnt_cnu != 4)  $display("FAIL nom_cnu_pulses: got %0d want 4", cnt_cnu); else n_pass++;
      n_total++; if (cnt_done != 1) $display("FAIL nom_done_pulses: got %0d want 1", cnt_done); else n_pass++;
   endtask

   task automatic test_max_iter();
      int got;
      got = -1;
      syn_ok = 1'b0; cnu_delay = 1; cnu_early = 1'b0;
      pulse_start();
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (n == 0) begin
            n_total++; if (success !== 1'b0) $display("FAIL max_success_cleared: got %b want 0", success); else n_pass++;
         end
         if (n == 204) begin
            n_total++; if ({busy, mem_rd_en, wr_en, done} !== 4'b1000) $display("FAIL max_chk0: busy/rd/wr/done=%b want 1000", {busy, mem_rd_en, wr_en, done}); else n_pass++;
         end
         if (n == 205) begin
            n_total++; if ({mem_rd_en, iter_cnt, layer_idx, col_idx} !== {1'b1, 3'd1, 2'd0, 5'd0})
               $display("FAIL max_iter1: rd=%b iter=%0d layer=%0d col=%0d want 1/1/0/0", mem_rd_en, iter_cnt, layer_idx, col_idx); else n_pass++;
         end
         if (done) begin
            got = n;
            n_total++; if ({success, iter_cnt, layer_idx} !== {1'b0, 3'd7, 2'd3})
               $display("FAIL max_done_state: success=%b iter=%0d layer=%0d want 0/7/3", success, iter_cnt, layer_idx); else n_pass++;
            break;
         end
      end
      n_total++; if (got != 1640) $display("FAIL max_latency: done at %0d want 1640", got); else n_pass++;
      @(posedge clk);
      #1;
      n_total++; if (cnt_cnu != 32) $display("FAIL max_cnu_pulses: got %0d want 32", cnt_cnu); else n_pass++;
      n_total++; if (cnt_done != 1) $display("FAIL max_done_pulses: got %0d want 1", cnt_done); else n_pass++;
   endtask

   task automatic test_cnu_delay();
      int got;
      got = -1;
      syn_ok = 1'b1; cnu_delay = 10; cnu_early = 1'b1;
      pulse_start();
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (n == 25) begin
            n_total++; if (cnu_start !== 1'b1) $display("FAIL dly_cnu_start: got %b want 1", cnu_start); else n_pass++;
         end
         if ((n >= 26) && (n <= 35)) begin
            n_total++; if ({busy, wr_en, cnu_start} !== 3'b100) $display("FAIL dly_wait_strobes n=%0d: busy/wr/cnu=%b want 100", n, {busy, wr_en, cnu_start}); else n_pass++;
            n_total++; if (col_idx !== 5'd23) $display("FAIL dly_col_stable n=%0d: col=%0d want 23", n, col_idx); else n_pass++;
         end
         if (n == 36) begin
            n_total++; if ({wr_en, col_idx} !== {1'b1, 5'd0}) $display("FAIL dly_wr_start: wr=%b col=%0d want 1/0", wr_en, col_idx); else n_pass++;
         end
         if (done) begin
            got = n;
            break;
         end
      end
      n_total++; if (got != 241) $display("FAIL dly_latency: done at %0d want 241", got); else n_pass++;
      cnu_delay = 1; cnu_early = 1'b0;
      @(posedge clk);
      #1;
      n_total++; if (cnt_cnu != 4) $display("FAIL dly_cnu_pulses: got %0d want 4", cnt_cnu); else n_pass++;
   endtask

   task automatic test_abort();
      int got;
      got = -1;
      syn_ok = 1'b0; cnu_delay = 1; cnu_early = 1'b0;
      pulse_start();
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (n == 749) begin
            got = n;
            n_total++; if ({wr_en, iter_cnt, layer_idx, col_idx} !== {1'b1, 3'd3, 2'd2, 5'd5})
               $display("FAIL abt_position: wr=%b iter=%0d layer=%0d col=%0d want 1/3/2/5", wr_en, iter_cnt, layer_idx, col_idx); else n_pass++;
            break;
         end
      end
      n_total++; if (got != 749) $display("FAIL abt_reach: got %0d want 749", got); else n_pass++;
      @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      n_total++; if ({busy, wr_en, mem_rd_en, cnu_start, done, success} !== 6'd0)
         $display("FAIL abt_idle: busy/wr/rd/cnu/done/success=%b want 000000", {busy, wr_en, mem_rd_en, cnu_start, done, success}); else n_pass++;
      n_total++; if ({col_idx, layer_idx, iter_cnt} !== 10'd0)
         $display("FAIL abt_counters: col=%0d layer=%0d iter=%0d want 0", col_idx, layer_idx, iter_cnt); else n_pass++;
      repeat (5) @(negedge clk);
      n_total++; if (cnt_done != 0) $display("FAIL abt_no_done: got %0d done pulses want 0", cnt_done); else n_pass++;
      got = -1;
      syn_ok = 1'b1;
      pulse_start();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (done) begin
            got = n;
            n_total++; if ({success, iter_cnt} !== {1'b1, 3'd0}) $display("FAIL abt_redo_state: success=%b iter=%0d want 1/0", success, iter_cnt); else n_pass++;
            break;
         end
      end
      n_total++; if (got != 205) $display("FAIL abt_redo_latency: done at %0d want 205", got); else n_pass++;
   endtask

   task automatic test_abort_chk();
      syn_ok = 1'b1; cnu_delay = 1; cnu_early = 1'b0;
      pulse_start();
      repeat (204) @(negedge clk);
      // abort raised for the CHK cycle, where syn_ok=1 would otherwise finish the decode
      @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      n_total++; if ({busy, done, success} !== 3'b000) $display("FAIL abt_chk_prio: busy/done/success=%b want 000", {busy, done, success}); else n_pass++;
      repeat (3) @(negedge clk);
      n_total++; if (cnt_done != 0) $display("FAIL abt_chk_no_done: got %0d want 0", cnt_done); else n_pass++;
   endtask

   task automatic test_start_abort_idle();
      @(posedge clk);
      #1 start = 1'b1; abort = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; abort = 1'b0;
      @(negedge clk);
      n_total++; if ({busy, mem_rd_en} !== 2'b00) $display("FAIL start_abort_idle: busy/rd=%b want 00", {busy, mem_rd_en}); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int got;
      got = -1;
      syn_ok = 1'b1; cnu_delay = 1; cnu_early = 1'b0;
      pulse_start();
      repeat (11) @(negedge clk);
      n_total++; if ({mem_rd_en, col_idx} !== {1'b1, 5'd10}) $display("FAIL rst_pre: rd=%b col=%0d want 1/10", mem_rd_en, col_idx); else n_pass++;
      // reset lands between clock edges; outputs must clear before the next rising edge
      #2 rst_n = 1'b0;
      #1;
      n_total++; if ({busy, mem_rd_en, en_q_compute, wr_en, cnu_start, done, success} !== 7'd0)
         $display("FAIL rst_async_out: outs=%b want 0000000", {busy, mem_rd_en, en_q_compute, wr_en, cnu_start, done, success}); else n_pass++;
      n_total++; if ({col_idx, layer_idx, iter_cnt} !== 10'd0)
         $display("FAIL rst_async_cnt: col=%0d layer=%0d iter=%0d want 0", col_idx, layer_idx, iter_cnt); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      pulse_start();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (n == 0) begin
            n_total++; if ({mem_rd_en, col_idx, layer_idx, iter_cnt} !== {1'b1, 10'd0})
               $display("FAIL rst_restart: rd=%b col=%0d layer=%0d iter=%0d want 1/0/0/0", mem_rd_en, col_idx, layer_idx, iter_cnt); else n_pass++;
         end
         if (n == 4) start = 1'b1;
         if (n == 5) start = 1'b0;
         if (n == 10) begin
            n_total++; if ({mem_rd_en, col_idx, layer_idx, iter_cnt} !== {1'b1, 5'd10, 2'd0, 3'd0})
               $display("FAIL busy_start_ignored: rd=%b col=%0d layer=%0d iter=%0d want 1/10/0/0", mem_rd_en, col_idx, layer_idx, iter_cnt); else n_pass++;
         end
         if (done) begin
            got = n;
            break;
         end
      end
      n_total++; if (got != 205) $display("FAIL rst_redo_latency: done at %0d want 205", got); else n_pass++;
   endtask

   task automatic test_invariants();
      n_total++; if (mon_err != 0) $display("FAIL monitor_invariants: %0d violations want 0", mon_err); else n_pass++;
      n_total++; if (mon_cyc < 2000) $display("FAIL monitor_coverage: %0d cycles watched want >= 2000", mon_cyc); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_max_iter();
      test_cnu_delay();
      test_abort();
      test_abort_chk();
      test_start_abort_idle();
      test_reset_mid();
      repeat (3) @(negedge clk);
      test_invariants();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
